// File: rtl/router_pkg.sv
// Shared types and header field layout for the router output-port receiver.
package router_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdrReq,
        StHdrWait,
        StBody,
        StDrain
    } rx_state_e;

    localparam int unsigned LEN_MSB     = 7;
    localparam int unsigned LEN_LSB     = 2;
    localparam int unsigned ADDR_MSB    = 1;
    localparam int unsigned MAX_PAYLOAD = 63;

    typedef struct packed {
        logic       err;
        logic       last;
        logic [7:0] data;
    } buf_entry_t;

    function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [1:0] hdr_addr(input logic [7:0] hdr);
        return hdr[ADDR_MSB:0];
    endfunction

endpackage

// File: rtl/router_rx_buf.sv
// Show-ahead payload FIFO holding {err, last, data} entries, with a free-entry count.
module router_rx_buf
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = 128
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_en,
    input  buf_entry_t                   wr_entry,
    input  logic                         rd_en,
    output buf_entry_t                   rd_entry,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   free
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    buf_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic            do_rd;

    assign valid    = (cnt_q != '0);
    assign do_rd    = rd_en & valid;
    assign free     = CW'(DEPTH) - cnt_q;
    // Drive zeros when empty so the stream outputs are clean after reset.
    assign rd_entry = valid ? mem[rd_ptr_q] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_en, do_rd})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr_q] <= wr_entry;
    end

endmodule

// File: rtl/router_port_rx.sv
// Receiver behind one router output port: pulls a packet, checks address/parity, streams payload.
// Optional statistics counters are built when ROUTER_RX_STATS_EN is defined.
module router_port_rx
    import router_pkg::*;
#(
    parameter int unsigned PORT      = 0,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned STALL_MAX = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_out,
    input  logic [7:0]  data_out,
    output logic        read_enb,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic [5:0]  pkt_len,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(STALL_MAX + 1);

    rx_state_e   state_q;
    logic        cap_q;
    logic [7:0]  hdr_q;
    logic [7:0]  parity_q;
    logic [6:0]  reads_left_q;
    logic [7:0]  hold_q;
    logic        hold_vld_q;
    logic [SW-1:0] stall_cnt_q;
    logic        fin_pend_q;
    logic        fin_err_q;
    logic        pkt_done_q;
    logic        pkt_err_q;
    logic [5:0]  pkt_len_q;

    logic        in_pkt;
    logic        stall_abort;
    logic        payload_cap;
    logic        parity_cap;
    logic        fin_err;
    logic        done_ev;
    logic        err_ev;
    logic        space_ok;
    logic        wr_en;
    buf_entry_t  wr_entry;
    buf_entry_t  rd_entry;
    logic [CW-1:0] buf_free;

    always_comb begin
        in_pkt      = (state_q == StBody) || (state_q == StDrain);
        stall_abort = in_pkt && !cap_q && (stall_cnt_q == SW'(STALL_MAX - 1));
        payload_cap = (state_q == StBody) && cap_q;
        parity_cap  = (state_q == StDrain) && cap_q;
        fin_err     = (parity_q != data_out) || (hdr_addr(hdr_q) != 2'(PORT));
        done_ev     = parity_cap | stall_abort;
        err_ev      = (parity_cap & fin_err) | stall_abort;
        // The final byte of a just-finished packet is still in flight while idle.
        space_ok    = buf_free >= (CW'(MAX_PAYLOAD) + CW'(fin_pend_q));

        read_enb = 1'b0;
        unique case (state_q)
            StHdrReq: read_enb = valid_out;
            StBody:   read_enb = valid_out && (reads_left_q != '0) && !stall_abort;
            default:  read_enb = 1'b0;
        endcase

        wr_en    = fin_pend_q | (hold_vld_q & (payload_cap | stall_abort));
        wr_entry = '{err: 1'b0, last: 1'b0, data: hold_q};
        if (fin_pend_q) begin
            wr_entry = '{err: fin_err_q, last: 1'b1, data: hold_q};
        end else if (stall_abort) begin
            wr_entry = '{err: 1'b1, last: 1'b1, data: hold_q};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cap_q        <= 1'b0;
            hdr_q        <= '0;
            parity_q     <= '0;
            reads_left_q <= '0;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            stall_cnt_q  <= '0;
            fin_pend_q   <= 1'b0;
            fin_err_q    <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_err_q    <= 1'b0;
            pkt_len_q    <= '0;
        end else begin
            cap_q      <= read_enb;
            pkt_done_q <= done_ev;
            pkt_err_q  <= err_ev;
            fin_pend_q <= parity_cap & hold_vld_q;
            fin_err_q  <= fin_err;
            if (done_ev) pkt_len_q <= hdr_len(hdr_q);

            if (in_pkt && !cap_q && !stall_abort) stall_cnt_q <= stall_cnt_q + SW'(1);
            else                                  stall_cnt_q <= '0;

            if (payload_cap) begin
                hold_q     <= data_out;
                hold_vld_q <= 1'b1;
                parity_q   <= parity_q ^ data_out;
            end

            unique case (state_q)
                StIdle: begin
                    if (valid_out && space_ok) state_q <= StHdrReq;
                end
                StHdrReq: begin
                    if (read_enb) state_q <= StHdrWait;
                end
                StHdrWait: begin
                    hdr_q        <= data_out;
                    parity_q     <= data_out;
                    reads_left_q <= {1'b0, hdr_len(data_out)} + 7'd1;
                    hold_vld_q   <= 1'b0;
                    state_q      <= StBody;
                end
                StBody: begin
                    if (stall_abort) begin
                        hold_vld_q <= 1'b0;
                        state_q    <= StIdle;
                    end else if (read_enb) begin
                        reads_left_q <= reads_left_q - 7'd1;
                        if (reads_left_q == 7'd1) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (stall_abort || cap_q) begin
                        hold_vld_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    router_rx_buf #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_entry (wr_entry),
        .rd_en    (out_ready),
        .rd_entry (rd_entry),
        .valid    (out_valid),
        .free     (buf_free)
    );

    assign out_data = rd_entry.data;
    assign out_last = rd_entry.last;
    assign out_err  = rd_entry.err;
    assign pkt_done = pkt_done_q;
    assign pkt_err  = pkt_err_q;
    assign pkt_len  = pkt_len_q;

`ifdef ROUTER_RX_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (done_ev && (pkt_cnt_q != 16'hFFFF)) pkt_cnt_q <= pkt_cnt_q + 16'd1;
            if (err_ev && (err_cnt_q != 16'hFFFF))  err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
    assign err_cnt = err_cnt_q;
`else
    assign pkt_cnt = '0;
    assign err_cnt = '0;
`endif

endmodule
